// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the issue logic and the
// multiply/divide unit.
//   master: drives start, op, a (rs), b (rt), hi_we, lo_we;
//           observes busy, done, div_by_zero, hi, lo.
//   slave : the unit itself (mirror directions).
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle; ITER steps per operation, result written to HI/LO on the last step.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-high reset, highest priority
//   bus    : mult_div_if.slave (start/op/a/b/hi_we/lo_we in,
//            busy/done/div_by_zero/hi/lo out)
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (bit1 = divide, bit0 = unsigned).
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   mult_div_if.slave  bus
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // Magnitude of x when treated as signed, raw value otherwise.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn_en);
      if (sgn_en && x[WIDTH-1]) begin
         mag = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag = x;
      end
   endfunction

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             psign_q, psign_d;   // product / quotient sign
   logic             rsign_q, rsign_d;   // remainder sign
   logic [WIDTH-1:0] acc_q, acc_d;       // product high word / partial remainder
   logic [WIDTH-1:0] mq_q, mq_d;         // multiplier / dividend-then-quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;       // multiplicand / divisor
   logic [WIDTH-1:0] aorig_q, aorig_d;   // raw A, returned in HI on divide-by-zero
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]     madd_s;
   logic [WIDTH+1:0]   dtrial_s;
   logic               dok_s;
   logic [WIDTH-1:0]   step_acc_s, step_mq_s;
   logic [2*WIDTH-1:0] prod_s;
   logic               is_div_s, is_sgn_s, acc_sgn_s;

   // Datapath step for the current iteration (multiply and divide flavours).
   always_comb begin
      is_div_s = op_q[1];
      is_sgn_s = ~op_q[0];
      // Multiply: add multiplicand when multiplier LSB set, then shift {acc,mq} right.
      madd_s   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
      // Divide: shift {acc,mq} left one, trial-subtract divisor. Partial
      // remainder stays below the divisor, so WIDTH+2 bits cannot overflow.
      dtrial_s = {1'b0, acc_q, mq_q[WIDTH-1]} - {2'b00, dvs_q};
      dok_s    = ~dtrial_s[WIDTH+1];
      if (is_div_s) begin
         step_acc_s = dok_s ? dtrial_s[WIDTH-1:0] : {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
         step_mq_s  = {mq_q[WIDTH-2:0], dok_s};
      end else begin
         step_acc_s = madd_s[WIDTH:1];
         step_mq_s  = {madd_s[0], mq_q[WIDTH-1:1]};
      end
      prod_s = {step_acc_s, step_mq_s};
   end

   // Next-state and output logic of the IDLE/RUN/FIN controller.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      psign_d   = psign_q;
      rsign_d   = rsign_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      dvs_d     = dvs_q;
      aorig_d   = aorig_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      acc_sgn_s = 1'b0;
      case (state_q)
         S_IDLE, S_FIN: begin
            if (bus.start) begin
               acc_sgn_s = ~bus.op[0];
               op_d      = bus.op;
               psign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               rsign_d   = bus.a[WIDTH-1];
               acc_d     = {WIDTH{1'b0}};
               aorig_d   = bus.a;
               cnt_d     = {CW{1'b0}};
               busy_d    = 1'b1;
               dbz_d     = 1'b0;
               state_d   = S_RUN;
               if (bus.op[1]) begin
                  mq_d  = mag(bus.a, acc_sgn_s);
                  dvs_d = mag(bus.b, acc_sgn_s);
               end else begin
                  mq_d  = mag(bus.b, acc_sgn_s);
                  dvs_d = mag(bus.a, acc_sgn_s);
               end
            end else begin
               state_d = S_IDLE;
               // MTHI/MTLO only when no operation is running or starting.
               if (bus.hi_we) begin
                  hi_d = bus.a;
               end else begin
                  hi_d = hi_q;
               end
               if (bus.lo_we) begin
                  lo_d = bus.a;
               end else begin
                  lo_d = lo_q;
               end
            end
         end
         S_RUN: begin
            acc_d = step_acc_s;
            mq_d  = step_mq_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_CNT) begin
               state_d = S_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (!is_div_s) begin
                  if (is_sgn_s && psign_q) begin
                     {hi_d, lo_d} = (~prod_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
                  end else begin
                     {hi_d, lo_d} = prod_s;
                  end
                  dbz_d = 1'b0;
               end else if (dvs_q == {WIDTH{1'b0}}) begin
                  lo_d  = {WIDTH{1'b1}};
                  hi_d  = aorig_q;
                  dbz_d = 1'b1;
               end else begin
                  // Magnitude divide yields 0x80000000 for MIN/-1, which the
                  // quotient negation leaves unchanged: overflow needs no special case.
                  lo_d  = (is_sgn_s && psign_q) ? (~step_mq_s) + {{(WIDTH-1){1'b0}}, 1'b1} : step_mq_s;
                  hi_d  = (is_sgn_s && rsign_q) ? (~step_acc_s) + {{(WIDTH-1){1'b0}}, 1'b1} : step_acc_s;
                  dbz_d = 1'b0;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         op_q    <= 2'b00;
         psign_q <= 1'b0;
         rsign_q <= 1'b0;
         acc_q   <= {WIDTH{1'b0}};
         mq_q    <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         aorig_q <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         psign_q <= psign_d;
         rsign_q <= rsign_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         dvs_q   <= dvs_d;
         aorig_q <= aorig_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Stimulus pushes the
// reference-model result for every accepted operation; a monitor pops and
// compares whenever DONE is seen.
module tb_mult_div_unit;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mult_div_if bus ();

   mult_div_unit dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t            r;
      longint          sa, sb, q, rm;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
         2'b01: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb; rm = sa % sb;
               r.lo = q[31:0]; r.hi = rm[31:0];
            end else begin
               p = ua / ub; r.lo = p[31:0];
               p = ua % ub; r.hi = p[31:0];
            end
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every DONE must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got DONE=1 expected no DONE");
            end else begin
               e = sb_q.pop_front();
               check("result_hi", {32'd0, bus.hi}, {32'd0, e.hi});
               check("result_lo", {32'd0, bus.lo}, {32'd0, e.lo});
               check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
            end
         end
      end
   end

   // Present a request for one edge; optionally log its expected result.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic hwe, input logic lwe);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.hi_we = hwe;
      bus.lo_we = lwe;
      if (push) sb_q.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   // Bounded wait for DONE; checks BUSY length and that DONE arrives.
   task automatic wait_done(input int exp_busy);
      int n    = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) n++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("done_seen", {63'd0, seen}, 64'd1);
      check("busy_cycles", n, exp_busy);
   endtask

   initial begin
      logic [31:0] lo_old;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lo_old, ra, rb;
      logic [1:0]  rop;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", {63'd0, bus.busy}, 64'd0);
      check("reset_done", {63'd0, bus.done}, 64'd0);
      check("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

      // Signed multiply -3 * 7.
      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0);
      wait_done(32);

      // MULTU max*max, then DIV -7/2 started in the FIN cycle.
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      wait_done(32);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
      wait_done(32);

      // Divide by zero, then a normal DIVU clears the flag.
      issue(2'b11, 32'd100, 32'd0, 1'b1, 1'b0, 1'b0);
      wait_done(32);
      issue(2'b11, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
      wait_done(32);
      check("dbz_cleared", {63'd0, bus.div_by_zero}, 64'd0);

      // Signed overflow and signed divide by zero.
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      wait_done(32);
      issue(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1, 1'b0, 1'b0);
      wait_done(32);

      // START and HI_WE while busy are ignored.
      issue(2'b01, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      issue(2'b10, 32'd77, 32'd3, 1'b0, 1'b1, 1'b0);
      check("busy_after_ignored_start", {63'd0, bus.busy}, 64'd1);
      wait_done(28);

      // Reset mid-operation aborts with no DONE and clears HI/LO.
      issue(2'b11, 32'd1000, 32'd9, 1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      repeat (40) @(negedge clk);

      // MTHI in idle; MTLO dropped when START is at the same edge.
      bus.a = 32'h1234_5678;
      bus.hi_we = 1'b1;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0;
      check("mthi", {32'd0, bus.hi}, 64'h1234_5678);
      lo_old = bus.lo;
      issue(2'b00, 32'h0000_0ABC, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1);
      check("start_beats_mtlo_busy", {63'd0, bus.busy}, 64'd1);
      check("start_beats_mtlo_lo", {32'd0, bus.lo}, {32'd0, lo_old});
      wait_done(32);

      // Randomized operations, some back-to-back, with idle MTHI/MTLO.
      for (int i = 0; i < 20; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
            bus.a = ra ^ 32'h5A5A_5A5A;
            bus.lo_we = 1'b1;
            @(posedge clk);
            #1;
            bus.lo_we = 1'b0;
            check("rand_mtlo", {32'd0, bus.lo}, {32'd0, ra ^ 32'h5A5A_5A5A});
         end
         issue(rop, ra, rb, 1'b1, 1'b0, 1'b0);
         wait_done(32);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
